// File: rtl/fft_pkg.sv
// Shared constants, state encoding and index helpers for the fft_out_stream block.
package fft_pkg;

  localparam int FFT_W_DEF      = 16;
  localparam int FFT_POINTS_DEF = 16;
  localparam int FFT_SHIFT_DEF  = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } fft_state_e;

  function automatic int fft_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // IFFT output reorder: sample j of the stream comes from input k = (p - j) mod p.
  function automatic int rev_idx(input int j, input int p);
    return (p - j) % p;
  endfunction

endpackage

// File: rtl/fft_scale.sv
// Single-sample signed scaler by 2^-SHIFT; round-toward-zero by default,
// round-half-away-from-zero when FFT_OUT_ROUND_EN is defined.
module fft_scale #(
  parameter int W     = 16,
  parameter int SHIFT = 4
) (
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_y
);

  logic         w_neg;
  logic [W:0]   w_ext;
  logic [W:0]   w_mag;
  logic [W:0]   w_q;
  logic [W:0]   w_res;

  // One extra bit so the magnitude of the most negative input stays exact.
  assign w_neg = i_x[W-1];
  assign w_ext = {i_x[W-1], i_x};
  assign w_mag = w_neg ? (~w_ext + (W+1)'(1)) : w_ext;

  generate
    if (SHIFT == 0) begin : g_ident
      assign w_q = w_mag;
    end else begin : g_shift
`ifdef FFT_OUT_ROUND_EN
      localparam logic [W:0] HALF = (W+1)'(1) << (SHIFT - 1);
      assign w_q = (w_mag + HALF) >> SHIFT;
`else
      assign w_q = w_mag >> SHIFT;
`endif
    end
  endgenerate

  assign w_res = w_neg ? (~w_q + (W+1)'(1)) : w_q;
  assign o_y   = W'(w_res);

endmodule

// File: rtl/fft_out_stream.sv
// Captures a parallel complex frame, scales and optionally IFFT-reorders it, then
// streams it over valid/ready. Rounding mode selected by FFT_OUT_ROUND_EN.
module fft_out_stream
  import fft_pkg::*;
#(
  parameter int W      = FFT_W_DEF,
  parameter int POINTS = FFT_POINTS_DEF,
  parameter int SHIFT  = FFT_SHIFT_DEF,
  localparam int LOG2P = fft_clog2(POINTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [POINTS*W-1:0]   in_re,
  input  logic [POINTS*W-1:0]   in_im,
  input  logic                  inv_order,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [W-1:0]          out_re,
  output logic [W-1:0]          out_im,
  output logic [LOG2P-1:0]      out_index,
  output logic                  out_last,
  output logic [15:0]           frame_cnt
);

  fft_state_e       r_state;
  fft_state_e       w_state_nxt;
  logic [LOG2P-1:0] r_rd_ptr;
  logic [15:0]      r_frame_cnt;
  logic [W-1:0]     r_buf_re [POINTS];
  logic [W-1:0]     r_buf_im [POINTS];
  logic [W-1:0]     w_sc_re  [POINTS];
  logic [W-1:0]     w_sc_im  [POINTS];

  logic w_out_valid;
  logic w_last;
  logic w_beat;
  logic w_in_ready;
  logic w_cap;

  generate
    for (genvar k = 0; k < POINTS; k++) begin : g_scale
      fft_scale #(.W(W), .SHIFT(SHIFT)) u_scale_re (
        .i_x (in_re[k*W +: W]),
        .o_y (w_sc_re[k])
      );
      fft_scale #(.W(W), .SHIFT(SHIFT)) u_scale_im (
        .i_x (in_im[k*W +: W]),
        .o_y (w_sc_im[k])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_cap) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_beat && w_last) w_state_nxt = w_cap ? ST_STREAM : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // A new frame may land on the last beat of the current one, so no bubble.
  always_comb begin
    w_out_valid = (r_state == ST_STREAM);
    w_last      = w_out_valid && (r_rd_ptr == LOG2P'(POINTS - 1));
    w_beat      = w_out_valid && out_ready;
    w_in_ready  = (r_state == ST_IDLE) || (w_beat && w_last);
    w_cap       = in_valid && w_in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_cap) begin
      r_rd_ptr <= '0;
    end else if (w_beat) begin
      r_rd_ptr <= r_rd_ptr + LOG2P'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_beat && w_last) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < POINTS; j++) begin
        r_buf_re[j] <= '0;
        r_buf_im[j] <= '0;
      end
    end else if (w_cap) begin
      for (int j = 0; j < POINTS; j++) begin
        r_buf_re[j] <= inv_order ? w_sc_re[rev_idx(j, POINTS)] : w_sc_re[j];
        r_buf_im[j] <= inv_order ? w_sc_im[rev_idx(j, POINTS)] : w_sc_im[j];
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_last  = w_last;
  assign out_re    = r_buf_re[r_rd_ptr];
  assign out_im    = r_buf_im[r_rd_ptr];
  assign out_index = r_rd_ptr;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_out_stream.sv
// Bench for fft_out_stream: queue-based reference model, directed and random traffic.
// Rounding expectations follow FFT_OUT_ROUND_EN when it is defined.
module tb_fft_out_stream;

  localparam int W      = 16;
  localparam int POINTS = 16;
  localparam int SHIFT  = 4;
  localparam int LOG2P  = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                inv_order = 1'b0;
  logic                out_ready = 1'b0;
  logic [POINTS*W-1:0] in_re = '0;
  logic [POINTS*W-1:0] in_im = '0;
  logic                in_ready;
  logic                out_valid;
  logic                out_last;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic [LOG2P-1:0]    out_index;
  logic [15:0]         frame_cnt;

  always #5 clk = ~clk;

  fft_out_stream #(.W(W), .POINTS(POINTS), .SHIFT(SHIFT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .inv_order (inv_order),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_index (out_index),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    int re;
    int im;
    int idx;
  } smp_t;

  smp_t exp_q[$];
  int   frames_m = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int ref_scale(input int x);
    int m;
    int q;
    m = (x < 0) ? -x : x;
`ifdef FFT_OUT_ROUND_EN
    q = (m + (1 << (SHIFT - 1))) / (1 << SHIFT);
`else
    q = m / (1 << SHIFT);
`endif
    return (x < 0) ? -q : q;
  endfunction

  function automatic int sample(input logic [POINTS*W-1:0] bus, input int k);
    logic signed [W-1:0] s;
    s = bus[k*W +: W];
    return int'(s);
  endfunction

  task automatic load_frame(input bit rnd);
    for (int k = 0; k < POINTS; k++) begin
      if (rnd) begin
        in_re[k*W +: W] = W'($urandom);
        in_im[k*W +: W] = W'($urandom);
      end else begin
        in_re[k*W +: W] = W'(16 * k);
        in_im[k*W +: W] = W'(-16 * k);
      end
    end
  endtask

  // Check outputs against the model for this cycle, then advance the model one clock.
  task automatic step();
    smp_t e;
    bit   have, last, beat, rdy;
    int   src;
    #1;
    have = (exp_q.size() != 0);
    last = have && (exp_q[0].idx == POINTS - 1);
    chk("out_valid", int'(out_valid), int'(have));
    if (have) begin
      e = exp_q[0];
      chk("out_re", int'(out_re), e.re);
      chk("out_im", int'(out_im), e.im);
      chk("out_index", int'(out_index), e.idx);
    end
    chk("out_last", int'(out_last), int'(last));
    beat = have && out_ready;
    rdy  = !have || (beat && last);
    chk("in_ready", int'(in_ready), int'(rdy));
    chk("frame_cnt", int'(frame_cnt), frames_m);
    if (beat) begin
      void'(exp_q.pop_front());
      if (last) frames_m = (frames_m + 1) % 65536;
    end
    if (in_valid && rdy) begin
      for (int j = 0; j < POINTS; j++) begin
        src   = inv_order ? (POINTS - j) % POINTS : j;
        e.re  = ref_scale(sample(in_re, src));
        e.im  = ref_scale(sample(in_im, src));
        e.idx = j;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_re", int'(out_re), 0);
    chk("rst_out_im", int'(out_im), 0);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Natural order ramp
    load_frame(1'b0);
    inv_order = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (17) step();
    chk("nat_frame_cnt", int'(frame_cnt), 1);

    // IFFT order ramp
    inv_order = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    #1 chk("ifft_b0_re", int'(out_re), 0);
    step();
    #1 chk("ifft_b1_re", int'(out_re), 15);
    step();
    #1 chk("ifft_b2_re", int'(out_re), 14);
    repeat (15) step();

    // Sign and rounding corner values in samples 0 and 1
    load_frame(1'b1);
    inv_order = 1'b0;
`ifdef FFT_OUT_ROUND_EN
    in_re[0*W +: W] = W'(-24);
    in_im[0*W +: W] = W'(8);
    in_re[1*W +: W] = W'(-8);
    in_im[1*W +: W] = W'(7);
`else
    in_re[0*W +: W] = W'(-17);
    in_im[0*W +: W] = W'(-15);
    in_re[1*W +: W] = W'(-32768);
    in_im[1*W +: W] = W'(31);
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef FFT_OUT_ROUND_EN
    #1 chk("rnd_m24", int'(out_re), -2);
    chk("rnd_p8", int'(out_im), 1);
    step();
    #1 chk("rnd_m8", int'(out_re), -1);
    chk("rnd_p7", int'(out_im), 0);
`else
    #1 chk("rtz_m17", int'(out_re), -1);
    chk("rtz_m15", int'(out_im), 0);
    step();
    #1 chk("rtz_min", int'(out_re), -2048);
    chk("rtz_p31", int'(out_im), 1);
`endif
    repeat (16) step();

    // Backpressure at index 3 with ignored in_valid pulses
    load_frame(1'b1);
    inv_order = 1'($urandom);
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      load_frame(1'b1);
      step();
      chk("bp_index_hold", int'(out_index), 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (14) step();

    // Back-to-back frames then reset mid-stream
    load_frame(1'b0);
    inv_order = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() > 1; i++) step();
    chk("b2b_reach_last", exp_q.size(), 1);
    load_frame(1'b1);
    inv_order = 1'b1;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    #1 chk("b2b_no_bubble", int'(out_valid), 1);
    chk("b2b_index0", int'(out_index), 0);
    repeat (7) step();
    #1 chk("pre_rst_index", int'(out_index), 7);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_frame_cnt", int'(frame_cnt), 0);
    chk("mrst_out_re", int'(out_re), 0);
    chk("mrst_out_last", int'(out_last), 0);
    exp_q.delete();
    frames_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      inv_order = 1'($urandom);
      load_frame(1'b1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
